// File: rtl/coef_serializer.sv
// Parallel NCHAN-entry complex vector to AXI-stream frame serializer with shadow/active buffering.
// Define COEF_SER_ASCEND_EN for ascending beat order (idx 0..NCHAN-1); default is descending.
module coef_serializer #(
  parameter int NCHAN = 32,
  parameter int DW    = 16,
  parameter int IDXW  = 5,
  parameter int CW    = 8
) (
  input  logic                       clk,
  input  logic                       aresetn,
  input  logic                       load,
  input  logic [NCHAN-1:0][DW-1:0]   din_real,
  input  logic [NCHAN-1:0][DW-1:0]   din_imag,
  output logic                       load_ready,
  output logic [2*DW-1:0]            m_axis_tdata,
  output logic [IDXW-1:0]            m_axis_tuser,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  output logic                       overrun,
  output logic [CW-1:0]              drop_count,
  output logic                       frame_done
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

`ifdef COEF_SER_ASCEND_EN
  localparam logic [IDXW-1:0] FIRST_IDX = '0;
  localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(NCHAN-1);
`else
  localparam logic [IDXW-1:0] FIRST_IDX = IDXW'(NCHAN-1);
  localparam logic [IDXW-1:0] LAST_IDX  = '0;
`endif

  logic [0:0]                 state;
  logic                       shadow_full;
  logic [NCHAN-1:0][DW-1:0]   shadow_real;
  logic [NCHAN-1:0][DW-1:0]   shadow_imag;
  logic [NCHAN-1:0][DW-1:0]   active_real;
  logic [NCHAN-1:0][DW-1:0]   active_imag;
  logic [IDXW-1:0]            idx;

  logic                       handshake;
  logic                       last_beat;
  logic                       start;
  logic                       send_nxt;
  logic                       load_acc;
  logic [IDXW-1:0]            step_idx;
  logic [IDXW-1:0]            idx_nxt;

  assign load_ready    = ~shadow_full;
  assign m_axis_tvalid = (state == SEND);
  assign m_axis_tuser  = idx;

  // A frame starts from idle or directly on the last beat, so frames chain without bubbles.
  always_comb begin
    handshake = (state == SEND) & m_axis_tready;
    last_beat = handshake & (idx == LAST_IDX);
    start     = shadow_full & ((state == IDLE) | last_beat);
    send_nxt  = start | ((state == SEND) & ~last_beat);
    load_acc  = load & ~shadow_full;
`ifdef COEF_SER_ASCEND_EN
    step_idx  = idx + 1'b1;
`else
    step_idx  = idx - 1'b1;
`endif
    if (start)
      idx_nxt = FIRST_IDX;
    else if (handshake)
      idx_nxt = step_idx;
    else
      idx_nxt = idx;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      shadow_real <= '0;
      shadow_imag <= '0;
      active_real <= '0;
      active_imag <= '0;
    end else begin
      if (load_acc) begin
        shadow_real <= din_real;
        shadow_imag <= din_imag;
      end
      if (start) begin
        active_real <= shadow_real;
        active_imag <= shadow_imag;
      end
    end
  end

  // Output data is registered from the next index so it always matches tuser.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state        <= IDLE;
      shadow_full  <= 1'b0;
      idx          <= '0;
      m_axis_tdata <= '0;
      m_axis_tlast <= 1'b0;
      overrun      <= 1'b0;
      drop_count   <= '0;
      frame_done   <= 1'b0;
    end else begin
      state        <= send_nxt ? SEND : IDLE;
      idx          <= idx_nxt;
      m_axis_tlast <= send_nxt & (idx_nxt == LAST_IDX);
      if (start)
        m_axis_tdata <= {shadow_imag[FIRST_IDX], shadow_real[FIRST_IDX]};
      else
        m_axis_tdata <= {active_imag[idx_nxt], active_real[idx_nxt]};
      if (load_acc)
        shadow_full <= 1'b1;
      else if (start)
        shadow_full <= 1'b0;
      overrun    <= load & shadow_full;
      frame_done <= last_beat;
      if (load && shadow_full && (drop_count != {CW{1'b1}}))
        drop_count <= drop_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_coef_serializer.sv
// Directed bench for coef_serializer; follows COEF_SER_ASCEND_EN to pick the expected beat order.
module tb_coef_serializer;

  localparam int NCHAN = 32;
  localparam int DW    = 16;
  localparam int IDXW  = 5;
  localparam int CW    = 8;

`ifdef COEF_SER_ASCEND_EN
  localparam logic [IDXW-1:0] LAST_IDX    = 5'd31;
  localparam logic [31:0]     FIRST_TDATA = 32'h0100_0000;
`else
  localparam logic [IDXW-1:0] LAST_IDX    = 5'd0;
  localparam logic [31:0]     FIRST_TDATA = 32'h011F_001F;
`endif

  logic                      clk = 1'b0;
  logic                      aresetn;
  logic                      load;
  logic [NCHAN-1:0][DW-1:0]  din_real;
  logic [NCHAN-1:0][DW-1:0]  din_imag;
  logic                      load_ready;
  logic [2*DW-1:0]           m_axis_tdata;
  logic [IDXW-1:0]           m_axis_tuser;
  logic                      m_axis_tvalid;
  logic                      m_axis_tready;
  logic                      m_axis_tlast;
  logic                      overrun;
  logic [CW-1:0]             drop_count;
  logic                      frame_done;

  int check_count = 0;
  int pass_count  = 0;

  coef_serializer #(.NCHAN(NCHAN), .DW(DW), .IDXW(IDXW), .CW(CW)) dut (
    .clk           (clk),
    .aresetn       (aresetn),
    .load          (load),
    .din_real      (din_real),
    .din_imag      (din_imag),
    .load_ready    (load_ready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .overrun       (overrun),
    .drop_count    (drop_count),
    .frame_done    (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    check_count++;
    if (got === exp)
      pass_count++;
    else
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic applyStimulus(input logic [15:0] rbase, input logic [15:0] ibase);
    for (int i = 0; i < NCHAN; i++) begin
      din_real[i] = rbase + 16'(i);
      din_imag[i] = ibase + 16'(i);
    end
  endtask

  function automatic logic [IDXW-1:0] exp_idx(input int j);
`ifdef COEF_SER_ASCEND_EN
    return IDXW'(j);
`else
    return IDXW'(NCHAN - 1 - j);
`endif
  endfunction

  function automatic logic [31:0] exp_data(input logic [15:0] rb, input logic [15:0] ib,
                                           input logic [IDXW-1:0] ix);
    logic [15:0] r;
    logic [15:0] m;
    r = rb + 16'(ix);
    m = ib + 16'(ix);
    return {m, r};
  endfunction

  // Called at a negedge where the first beat is already visible; mode 1 adds backpressure.
  task automatic collect(input int nframes, input int mode, input int load_at,
                         input logic [15:0] r0, input logic [15:0] i0,
                         input logic [15:0] r1, input logic [15:0] i1);
    int              k = 0;
    int              cyc = 0;
    int              stall_left = 0;
    int              done_cnt = 0;
    bit              stall_done = 0;
    bit              loaded = 0;
    int              nbeats;
    logic [IDXW-1:0] ei;
    logic [15:0]     rb;
    logic [15:0]     ib;
    nbeats = nframes * NCHAN;
    while (k < nbeats && cyc < nbeats * 4 + 40) begin
      ei = exp_idx(k % NCHAN);
      rb = (k < NCHAN) ? r0 : r1;
      ib = (k < NCHAN) ? i0 : i1;
      if (mode == 1) begin
        if (!stall_done && ei == 5'd17) begin
          stall_left = 5;
          stall_done = 1;
        end
        if (stall_left > 0) begin
          m_axis_tready = 1'b0;
          stall_left--;
        end else begin
          m_axis_tready = (cyc % 2 == 0);
        end
      end else begin
        m_axis_tready = 1'b1;
      end
      checkOutput("tvalid", m_axis_tvalid, 1);
      checkOutput("tuser", m_axis_tuser, ei);
      checkOutput("tdata", m_axis_tdata, exp_data(rb, ib, ei));
      checkOutput("tlast", m_axis_tlast, ei == LAST_IDX);
      if (frame_done) done_cnt++;
      if (k == load_at && !loaded) begin
        applyStimulus(r1, i1);
        load = 1'b1;
        loaded = 1;
      end else begin
        load = 1'b0;
      end
      if (m_axis_tvalid && m_axis_tready) k++;
      @(negedge clk);
      cyc++;
    end
    load = 1'b0;
    checkOutput("beat_count", k, nbeats);
    if (frame_done) done_cnt++;
    checkOutput("idle_after", m_axis_tvalid, 0);
    @(negedge clk);
    if (frame_done) done_cnt++;
    checkOutput("frame_done_cnt", done_cnt, nframes);
  endtask

  task automatic start_frame(input logic [15:0] rb, input logic [15:0] ib, input string tag);
    applyStimulus(rb, ib);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    checkOutput({tag, "_lat1_tvalid"}, m_axis_tvalid, 0);
    checkOutput({tag, "_lat1_ready"}, load_ready, 0);
    @(negedge clk);
    checkOutput({tag, "_lat2_tvalid"}, m_axis_tvalid, 1);
  endtask

  initial begin
    aresetn = 1'b0;
    load = 1'b0;
    m_axis_tready = 1'b0;
    applyStimulus(16'h0, 16'h0);
    repeat (3) @(negedge clk);
    checkOutput("rst_tvalid", m_axis_tvalid, 0);
    checkOutput("rst_tlast", m_axis_tlast, 0);
    checkOutput("rst_tdata", m_axis_tdata, 0);
    checkOutput("rst_tuser", m_axis_tuser, 0);
    checkOutput("rst_overrun", overrun, 0);
    checkOutput("rst_frame_done", frame_done, 0);
    checkOutput("rst_drop_count", drop_count, 0);
    checkOutput("rst_load_ready", load_ready, 1);
    aresetn = 1'b1;
    m_axis_tready = 1'b1;
    @(negedge clk);

    $display("[TB] single frame");
    start_frame(16'h0000, 16'h0100, "single");
    checkOutput("first_tdata", m_axis_tdata, FIRST_TDATA);
    collect(1, 0, -1, 16'h0000, 16'h0100, 16'h0000, 16'h0100);

    $display("[TB] backpressure");
    start_frame(16'h0000, 16'h0100, "bp");
    collect(1, 1, -1, 16'h0000, 16'h0100, 16'h0000, 16'h0100);

    $display("[TB] back-to-back");
    start_frame(16'h0000, 16'h0100, "b2b");
    collect(2, 0, 9, 16'h0000, 16'h0100, 16'h0200, 16'h0300);

    $display("[TB] overrun");
    m_axis_tready = 1'b0;
    applyStimulus(16'h0000, 16'h0100);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_start", load_ready, 1);
    applyStimulus(16'h0200, 16'h0300);
    load = 1'b1;
    @(negedge clk);
    applyStimulus(16'h0400, 16'h0500);
    @(negedge clk);
    load = 1'b0;
    checkOutput("overrun_pulse", overrun, 1);
    checkOutput("drop_count_1", drop_count, 1);
    checkOutput("ready_full", load_ready, 0);
    @(negedge clk);
    checkOutput("overrun_once", overrun, 0);
    @(negedge clk);
    collect(2, 0, -1, 16'h0000, 16'h0100, 16'h0200, 16'h0300);

    m_axis_tready = 1'b0;
    applyStimulus(16'h0600, 16'h0700);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    applyStimulus(16'h0800, 16'h0900);
    load = 1'b1;
    @(negedge clk);
    checkOutput("no_drop_on_accept", drop_count, 1);
    repeat (253) @(negedge clk);
    checkOutput("drop_near_sat", drop_count, 254);
    repeat (47) @(negedge clk);
    load = 1'b0;
    checkOutput("drop_saturated", drop_count, 255);

    $display("[TB] reset mid-frame");
    m_axis_tready = 1'b1;
    repeat (12) @(negedge clk);
    checkOutput("pre_reset_tuser", m_axis_tuser, exp_idx(12));
    checkOutput("pre_reset_tdata", m_axis_tdata, exp_data(16'h0600, 16'h0700, exp_idx(12)));
    aresetn = 1'b0;
    #1;
    checkOutput("async_tvalid", m_axis_tvalid, 0);
    checkOutput("async_tdata", m_axis_tdata, 0);
    checkOutput("async_ready", load_ready, 1);
    checkOutput("async_drop_count", drop_count, 0);
    @(negedge clk);
    aresetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("no_stale_frame", m_axis_tvalid, 0);
    end
    start_frame(16'h0000, 16'h0100, "post_rst");
    collect(1, 0, -1, 16'h0000, 16'h0100, 16'h0000, 16'h0100);

    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/coef_serializer.md
Name: coef_serializer

Overview:
- AXI-stream master that converts a parallel NCHAN-entry complex vector into one serial frame per vector. It is the transmit-side counterpart of the linterp serial-to-parallel collector.
- Frames use the same beat order and tlast convention as the fader-to-IFFT path, so a parallel coefficient or channel set can be fed back into the fade_ifft or win pipeline.
- Double-buffered (shadow + active), so back-to-back frames stream without bubbles.

Parameters:
- NCHAN, 32, entries per frame (beats per frame).
- DW, 16, bits per real/imag component.
- IDXW, 5, index width, equal to clog2(NCHAN).
- CW, 8, width of the drop counter.

Ports:
- clk  in  1  system clock.
- aresetn  in  1  asynchronous, active-low reset.
- load  in  1  capture strobe for din_real/din_imag.
- din_real  in  NCHAN x DW  parallel real parts.
- din_imag  in  NCHAN x DW  parallel imag parts.
- load_ready  out  1  shadow buffer empty; a load is accepted this cycle.
- m_axis_tdata  out  2*DW  {imag, real} of the current entry.
- m_axis_tuser  out  IDXW  entry index of the current beat.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last beat of the frame.
- overrun  out  1  one-cycle pulse when a load is dropped.
- drop_count  out  CW  saturating count of dropped loads.
- frame_done  out  1  one-cycle pulse after the last-beat handshake.

Behaviour:
- Reset (async assert, sync release): shadow_full=0, active empty, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tuser=0, overrun=0, frame_done=0, drop_count=0. A reset mid-frame drops tvalid immediately and discards both buffers.
- load_ready = ~shadow_full.
- Load accepted (load & load_ready): the full vector is captured into shadow and shadow_full is set.
- Load dropped (load & ~load_ready): overrun pulses high the next cycle. drop_count increments and saturates at 2^CW-1.
- States:
  - IDLE: tvalid=0.
  - SEND: tvalid=1, idx holds the current entry.
- IDLE -> SEND: on a clock edge with shadow_full=1, copy shadow to active, clear shadow_full, set idx=NCHAN-1. tvalid is high in the following cycle.
- Latency: load sampled at edge t gives first tvalid after edge t+1 (2 cycles).
- Beat order: descending, idx NCHAN-1 down to 0. m_axis_tlast = (idx==0) & tvalid.
- Registered outputs: m_axis_tdata = {active_imag[idx], active_real[idx]}, m_axis_tuser = idx.
- Handshake (tvalid & tready): advance idx by one.
  - Last beat with shadow_full=1: reload active from shadow, set idx=NCHAN-1, and keep tvalid high. This gives zero bubble cycles between frames.
  - Last beat with shadow_full=0: go to IDLE.
  - Both cases pulse frame_done for one cycle.
- AXI rules while tvalid=1 and tready=0: tdata, tuser and tlast hold stable and tvalid stays high. tvalid never depends combinationally on tready.
- A load accepted during SEND fills shadow only. The active frame is never modified mid-frame.
- Same-edge last-beat handshake and load: load_ready reflects shadow_full before the edge.
  - If shadow was full, the load is dropped, even though shadow empties on that edge.
  - If shadow was empty, the load lands in shadow and the next frame follows after one IDLE->SEND edge.

Optional Feature:
COEF_SER_ASCEND_EN
- Defined: beats go in ascending order, idx 0 to NCHAN-1, with m_axis_tlast = (idx==NCHAN-1) & tvalid. The frame start sets idx=0.
- Undefined: descending order as above, matching the fader chan_out convention that the FFT framing expects.
- All other timing is identical in both modes.

Test Plan:
- Single frame: reset, load din_real[i]=i and din_imag[i]=0x100+i with tready=1 -> tvalid rises 2 cycles after load; 32 consecutive beats with tuser 31..0 and tdata {0x11F,0x001F} first; tlast only on tuser=0; one frame_done pulse; then IDLE.
- Backpressure: the same frame with tready toggling 1010, plus a 5-cycle tready=0 stall at tuser=17 -> data and tuser held stable during stalls; exactly 32 handshakes; no beat duplicated or lost.
- Back-to-back frames: load A, then load B during A's 10th beat, tready=1 -> B's tuser=31 follows A's tlast on the very next cycle; 64 beats with no gap.
- Overrun: load A, load B, then load C while shadow is full -> overrun pulses once; drop_count=1; C never appears; 300 further dropped loads -> drop_count saturates at 255.
- Reset mid-frame: deassert aresetn at beat 12 -> tvalid=0 asynchronously; after release load_ready=1 and drop_count=0; a new load produces a clean full 32-beat frame.
- COEF_SER_ASCEND_EN defined, repeat the single-frame test -> tuser 0..31; first tdata {0x100,0x0000}; tlast on tuser=31.
